top: RTL and testbench

TOP -- requirements
Module: top

---
 rtl/top.sv | 112 +++++++++++
 tb/tb_top.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/top.sv
// Four-bit universal shift register (SISO/SIPO/PISO/PIPO) whose storage is a
// Hamming(7,4) codeword, corrected on read and re-encoded (scrubbed) every clock.
module top (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] mode,
    input  logic       load,
    input  logic       siso_in,
    input  logic [3:0] parallel_in,
    output logic       siso_out,
    output logic [3:0] parallel_out
);

    localparam logic [1:0] MODE_SISO = 2'b00;
    localparam logic [1:0] MODE_SIPO = 2'b01;
    localparam logic [1:0] MODE_PISO = 2'b10;
    localparam logic [1:0] MODE_PIPO = 2'b11;

    // Codeword layout [6:0] = {D3, D2, D1, P4, D0, P2, P1}
    function automatic logic [6:0] hamming_encode(input logic [3:0] d);
        logic p1;
        logic p2;
        logic p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    function automatic logic [2:0] hamming_syndrome(input logic [6:0] cw);
        logic s1;
        logic s2;
        logic s4;
        s1 = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
        s2 = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
        s4 = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
        return {s4, s2, s1};
    endfunction

    // Syndrome value names the 1-based position of the bit to invert.
    function automatic logic [3:0] hamming_correct(input logic [6:0] cw);
        logic [6:0] flip;
        logic [6:0] fixed;
        case (hamming_syndrome(cw))
            3'd1:    flip = 7'b000_0001;
            3'd2:    flip = 7'b000_0010;
            3'd3:    flip = 7'b000_0100;
            3'd4:    flip = 7'b000_1000;
            3'd5:    flip = 7'b001_0000;
            3'd6:    flip = 7'b010_0000;
            3'd7:    flip = 7'b100_0000;
            default: flip = 7'b000_0000;
        endcase
        fixed = cw ^ flip;
        return {fixed[6], fixed[5], fixed[4], fixed[2]};
    endfunction

    logic [6:0] reg_data;
    logic [6:0] reg_data_d;
    logic [3:0] data_s;
    logic [3:0] data_next_s;

    // Decode the stored codeword; outputs never see an uncorrected bit.
    always_comb begin
        data_s       = hamming_correct(reg_data);
        parallel_out = data_s;
        siso_out     = data_s[3];
    end

    // Next-data selection; load outranks enable in the parallel-load modes.
    always_comb begin
        data_next_s = data_s;
        case (mode)
            MODE_SISO, MODE_SIPO: begin
                if (enable) begin
                    data_next_s = {data_s[2:0], siso_in};
                end else begin
                    data_next_s = data_s;
                end
            end
            MODE_PISO: begin
                if (load) begin
                    data_next_s = parallel_in;
                end else if (enable) begin
                    data_next_s = {data_s[2:0], 1'b0};
                end else begin
                    data_next_s = data_s;
                end
            end
            MODE_PIPO: begin
                if (load) begin
                    data_next_s = parallel_in;
                end else begin
                    data_next_s = data_s;
                end
            end
            default: data_next_s = data_s;
        endcase
        reg_data_d = hamming_encode(data_next_s);
    end

    // Codeword register, rewritten every edge so single-bit upsets are scrubbed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_data <= 7'b000_0000;
        end else begin
            reg_data <= reg_data_d;
        end
    end

endmodule

// File: tb/tb_top.sv
// Directed self-checking bench for the Hamming-protected universal shift register.
module tb_top;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [1:0] mode;
    logic       load;
    logic       siso_in;
    logic [3:0] parallel_in;
    logic       siso_out;
    logic [3:0] parallel_out;

    int checks;
    int failures;

    top dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .mode         (mode),
        .load         (load),
        .siso_in      (siso_in),
        .parallel_in  (parallel_in),
        .siso_out     (siso_out),
        .parallel_out (parallel_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 1'b1; mode = 2'b10; load = 1'b1;
        siso_in = 1'b1; parallel_in = 4'b1111;
        #2;
        checks++;
        if ({siso_out, parallel_out} !== 5'b0_0000) begin
            failures++;
            $display("FAIL reset_async_outputs: got %b expected %b", {siso_out, parallel_out}, 5'b0_0000);
        end
        tick();
        checks++;
        if (dut.reg_data !== 7'b000_0000) begin
            failures++;
            $display("FAIL reset_reg_data: got %b expected %b", dut.reg_data, 7'b000_0000);
        end
        enable = 1'b0; load = 1'b0; mode = 2'b00;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({siso_out, parallel_out, dut.reg_data} !== 12'b0_0000_0000000) begin
            failures++;
            $display("FAIL reset_release_hold: got %b expected %b", {siso_out, parallel_out, dut.reg_data}, 12'b0);
        end
    endtask

    task automatic test_siso();
        mode = 2'b00; enable = 1'b1; siso_in = 1'b1;
        tick();
        checks++;
        if (parallel_out !== 4'b0001) begin
            failures++;
            $display("FAIL siso_shift1: got %b expected %b", parallel_out, 4'b0001);
        end
        siso_in = 1'b0;
        tick();
        checks++;
        if (parallel_out !== 4'b0010) begin
            failures++;
            $display("FAIL siso_shift2: got %b expected %b", parallel_out, 4'b0010);
        end
        enable = 1'b0; siso_in = 1'b1;
        tick();
        tick();
        checks++;
        if ({parallel_out, dut.reg_data} !== {4'b0010, 7'b0011001}) begin
            failures++;
            $display("FAIL siso_hold: got %b/%b expected %b/%b", parallel_out, dut.reg_data, 4'b0010, 7'b0011001);
        end
    endtask

    task automatic test_fault_scrub();
        logic [6:0] clean;
        logic [6:0] bad;
        int         idx [3] = '{2, 1, 3};
        clean  = 7'b0011001;
        enable = 1'b0; mode = 2'b00;
        for (int k = 0; k < 3; k++) begin
            bad = clean ^ (7'b000_0001 << idx[k]);
            force dut.reg_data = bad;
            #1;
            checks++;
            if ({siso_out, parallel_out} !== 5'b0_0010) begin
                failures++;
                $display("FAIL scrub_flip%0d_outputs: got %b expected %b", idx[k], {siso_out, parallel_out}, 5'b0_0010);
            end
            release dut.reg_data;
            tick();
            checks++;
            if (dut.reg_data !== clean) begin
                failures++;
                $display("FAIL scrub_flip%0d_reencode: got %b expected %b", idx[k], dut.reg_data, clean);
            end
        end
    endtask

    task automatic test_mode_change();
        mode = 2'b11; load = 1'b0; enable = 1'b1;
        tick();
        checks++;
        if (parallel_out !== 4'b0010) begin
            failures++;
            $display("FAIL mode_change_preserve: got %b expected %b", parallel_out, 4'b0010);
        end
    endtask

    task automatic test_piso();
        mode = 2'b10; parallel_in = 4'b1011; load = 1'b1; enable = 1'b0;
        tick();
        checks++;
        if ({siso_out, parallel_out, dut.reg_data} !== {1'b1, 4'b1011, 7'b1010101}) begin
            failures++;
            $display("FAIL piso_load: got %b expected %b", {siso_out, parallel_out, dut.reg_data}, {1'b1, 4'b1011, 7'b1010101});
        end
        load = 1'b0; enable = 1'b1; parallel_in = 4'b0000;
        tick();
        checks++;
        if ({siso_out, parallel_out} !== 5'b0_0110) begin
            failures++;
            $display("FAIL piso_shift1: got %b expected %b", {siso_out, parallel_out}, 5'b0_0110);
        end
        tick();
        checks++;
        if ({siso_out, parallel_out} !== 5'b1_1100) begin
            failures++;
            $display("FAIL piso_shift2: got %b expected %b", {siso_out, parallel_out}, 5'b1_1100);
        end
        load = 1'b1; enable = 1'b1; parallel_in = 4'b0101;
        tick();
        checks++;
        if ({siso_out, parallel_out} !== 5'b0_0101) begin
            failures++;
            $display("FAIL piso_load_priority: got %b expected %b", {siso_out, parallel_out}, 5'b0_0101);
        end
        load = 1'b0;
    endtask

    task automatic test_pipo();
        mode = 2'b11; parallel_in = 4'b1101; load = 1'b1; enable = 1'b0;
        tick();
        checks++;
        if ({siso_out, parallel_out} !== 5'b1_1101) begin
            failures++;
            $display("FAIL pipo_load: got %b expected %b", {siso_out, parallel_out}, 5'b1_1101);
        end
        load = 1'b0; enable = 1'b1;
        force dut.reg_data = 7'b0001100;
        #1;
        checks++;
        if ({siso_out, parallel_out} !== 5'b1_1001) begin
            failures++;
            $display("FAIL pipo_forced_decode: got %b expected %b", {siso_out, parallel_out}, 5'b1_1001);
        end
        release dut.reg_data;
        tick();
        checks++;
        if (dut.reg_data !== 7'b1001100 || $isunknown({siso_out, parallel_out})) begin
            failures++;
            $display("FAIL pipo_reencode: got %b out %b expected %b", dut.reg_data, parallel_out, 7'b1001100);
        end
    endtask

    task automatic test_sipo();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        mode = 2'b01; enable = 1'b1; load = 1'b0; siso_in = 1'b1;
        tick();
        checks++;
        if (parallel_out !== 4'b0001) begin
            failures++;
            $display("FAIL sipo_shift1: got %b expected %b", parallel_out, 4'b0001);
        end
        tick();
        checks++;
        if (parallel_out !== 4'b0011) begin
            failures++;
            $display("FAIL sipo_shift2: got %b expected %b", parallel_out, 4'b0011);
        end
        enable = 1'b0; load = 1'b1; parallel_in = 4'b1111;
        tick();
        checks++;
        if (parallel_out !== 4'b0011) begin
            failures++;
            $display("FAIL sipo_load_ignored: got %b expected %b", parallel_out, 4'b0011);
        end
        mode = 2'b00;
        tick();
        checks++;
        if (parallel_out !== 4'b0011) begin
            failures++;
            $display("FAIL siso_load_ignored: got %b expected %b", parallel_out, 4'b0011);
        end
        load = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        mode = 2'b10; enable = 1'b1; load = 1'b1; parallel_in = 4'b1110;
        tick();
        load = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({siso_out, parallel_out, dut.reg_data} !== 12'b0) begin
            failures++;
            $display("FAIL reset_mid_shift: got %b expected %b", {siso_out, parallel_out, dut.reg_data}, 12'b0);
        end
        tick();
        checks++;
        if (parallel_out !== 4'b0000) begin
            failures++;
            $display("FAIL reset_held_during_shift: got %b expected %b", parallel_out, 4'b0000);
        end
        enable = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_siso();
        test_fault_scrub();
        test_mode_change();
        test_piso();
        test_pipo();
        test_sipo();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
